// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states and
// opcode-class helpers.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int SHAMT_W       = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic logic is_logic_op(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] <= 3'd4);
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/logic_eval.sv
// Combinational evaluator for the five bitwise ALU operations, selected by
// the low three opcode bits.
module logic_eval
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] result_o
);

  // NOTE: assigning a default before the case keeps every path driven, so
  // no latch is inferred for codes the case does not list.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND[2:0]: result_o = x_i & y_i;
      OP_OR[2:0]:  result_o = x_i | y_i;
      OP_NOR[2:0]: result_o = ~(x_i | y_i);
      OP_XOR[2:0]: result_o = x_i ^ y_i;
      OP_NOT[2:0]: result_o = ~x_i;
      default:     ;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle logic ops, iterative one-bit-per-cycle
// shifter, and a valid/ready handshake on both sides.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic             busy
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [1:0]           shop_q, shop_d;
  logic                 illegal_q, illegal_d;
  logic [WIDTH-1:0]     logic_res;
  logic [WIDTH-1:0]     shift_step;
  logic [SHAMT_W-1:0]   shamt;
  logic                 accept;

  logic_eval #(.WIDTH(WIDTH)) u_logic_eval (
    .op_i     (in_op[2:0]),
    .x_i      (in_x),
    .y_i      (in_y),
    .result_o (logic_res)
  );

  assign shamt    = in_y[SHAMT_W-1:0];
  // Gated by rst so upstream sees no capacity while reset is held.
  assign in_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    shift_step = {shreg_q[WIDTH-2:0], 1'b0};
    if (shop_q == OP_SRL[1:0]) begin
      shift_step = {1'b0, shreg_q[WIDTH-1:1]};
    end else if (shop_q == OP_SRA[1:0]) begin
      shift_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    count_d   = count_q;
    shop_d    = shop_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_SHIFT: begin
        shreg_d = shift_step;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d  = shift_step;
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: ;
    endcase

    // An accept can only occur in IDLE or DONE, so it overrides the above.
    if (accept) begin
      illegal_d = 1'b0;
      state_d   = ST_DONE;
      if (is_logic_op(in_op)) begin
        result_d = logic_res;
      end else if (is_shift_op(in_op)) begin
        if (shamt == '0) begin
          result_d = in_x;
        end else begin
          shreg_d = in_x;
          count_d = shamt;
          shop_d  = in_op[1:0];
          state_d = ST_SHIFT;
        end
      end else begin
        result_d  = '0;
        illegal_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      result_q  <= '0;
      count_q   <= '0;
      shop_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      result_q  <= result_d;
      count_q   <= count_d;
      shop_q    <= shop_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign out_result  = result_q;
  assign out_zero    = (result_q == '0);
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage: hand-computed vectors
// covering logic ops, iterative shifts, back-pressure, illegal ops and reset.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int lat;
  int seen;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_x        (in_x),
    .in_y        (in_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    in_op    = op;
    in_x     = x;
    in_y     = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    // AND, latency 1
    out_ready = 1'b1;
    drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    @(negedge clk);
    in_valid = 1'b0;
    check("and_valid", 32'(out_valid), 32'd1);
    check("and_result", out_result, 32'hF000_F000);
    check("and_zero", 32'(out_zero), 32'd0);
    check("and_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_result_held", out_result, 32'hF000_F000);

    // SRA by 4, iterative
    drive(4'b1010, 32'h8000_0000, 32'd4);
    @(negedge clk);
    in_valid = 1'b0; in_x = 32'hFFFF_FFFF; in_op = 4'b0000;
    lat = 0;
    check("sra_in_ready_shift", 32'(in_ready), 32'd0);
    check("sra_busy_shift", 32'(busy), 32'd1);
    check("sra_result_held", out_result, 32'hF000_F000);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!out_valid) check("sra_in_ready_shift_loop", 32'(in_ready), 32'd0);
    end
    check("sra_latency", 32'(lat), 32'd4);
    check("sra_result", out_result, 32'hF800_0000);

    // SLL shamt 0 back-to-back from DONE; upper Y bits must be ignored
    drive(4'b1000, 32'h1234_5678, 32'hFFFF_FFE0);
    @(negedge clk);
    check("sll0_valid", 32'(out_valid), 32'd1);
    check("sll0_result", out_result, 32'h1234_5678);

    // SRL by 31, back-to-back
    drive(4'b1001, 32'hFFFF_FFFF, 32'd31);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    check("srl_valid_shift", 32'(out_valid), 32'd0);
    check("srl_result_held", out_result, 32'h1234_5678);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("srl_latency", 32'(lat), 32'd31);
    check("srl_result", out_result, 32'd1);
    check("srl_zero", 32'(out_zero), 32'd0);
    @(negedge clk);

    // XOR to zero with back-pressure, then same-edge handoff to OR
    out_ready = 1'b0;
    drive(4'b0011, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(4'b0001, 32'h0000_000F, 32'h0000_00F0);
    check("xor_valid", 32'(out_valid), 32'd1);
    check("xor_result", out_result, 32'd0);
    check("xor_zero", 32'(out_zero), 32'd1);
    check("xor_in_ready_stall", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", out_result, 32'd0);
      check("stall_zero", 32'(out_zero), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("or_handoff_valid", 32'(out_valid), 32'd1);
    check("or_handoff_result", out_result, 32'h0000_00FF);

    // Illegal opcode, then NOT back-to-back
    drive(4'b0111, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check("illegal_flag", 32'(out_illegal), 32'd1);
    check("illegal_result", out_result, 32'd0);
    check("illegal_valid", 32'(out_valid), 32'd1);
    drive(4'b0100, 32'd0, 32'hAAAA_AAAA);
    @(negedge clk);
    in_valid = 1'b0;
    check("not_result", out_result, 32'hFFFF_FFFF);
    check("not_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk);

    // Reset mid-way through SLL by 20
    drive(4'b1000, 32'd1, 32'd20);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("sll20_busy", 32'(busy), 32'd1);
    check("sll20_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_result", out_result, 32'd0);
    check("midrst_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("no_valid_after_rst", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
